// File: rtl/udp_tx_stream.sv
// Buffers one UDP datagram of 32-bit payload words and then streams it as a complete
// Ethernet/IPv4/UDP frame, one byte at a time, on the MAC's address/advance handshake.
module udp_tx_stream #(
  parameter logic [47:0] MY_HWADDR  = 48'h985aebdd1c65,
  parameter logic [47:0] DST_HWADDR = 48'h985aebdd1c64,
  parameter logic [31:0] MY_IP      = 32'hc0a80205,
  parameter logic [31:0] DST_IP     = 32'hc0a80202,
  parameter logic [15:0] SRC_PORT   = 16'h4e50,
  parameter logic [15:0] DST_PORT   = 16'h4e50,
  parameter logic [7:0]  TTL        = 8'h40,
  parameter int          MAX_WORDS  = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic        tx_req,
  output logic [10:0] tx_count,
  input  logic        tx_grant,
  input  logic [10:0] tx_addr,
  input  logic        tx_adv,
  input  logic        tx_last,
  output logic [7:0]  tx_data,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready
);

  localparam int NW = $clog2(MAX_WORDS + 1);
  localparam int AW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    FILL = 6'b000010,
    CSUM = 6'b000100,
    ARB  = 6'b001000,
    HDR  = 6'b010000,
    DATA = 6'b100000
  } state_t;

  state_t      r_state;
  logic [NW-1:0] r_n;
  logic [31:0] r_buf [MAX_WORDS];
  logic [15:0] r_ipId;
  logic [15:0] r_ipLen;
  logic [15:0] r_udpLen;
  logic [15:0] r_cksum;
  logic [10:0] r_txCount;
  logic [7:0]  r_txData;

  logic          w_accept;
  logic [NW-1:0] w_nNext;
  logic          w_full;
  logic          w_sending;
  logic [10:0]   w_payBytes;
  logic [15:0]   w_ipLenN;
  logic [15:0]   w_udpLenN;
  logic [19:0]   w_sum;
  logic [16:0]   w_fold1;
  logic [15:0]   w_fold2;
  logic [10:0]   w_frameLen;
  logic [10:0]   w_txCountN;
  logic [335:0]  w_hdr;
  logic [5:0]    w_hdrIdx;
  logic [10:0]   w_off;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;

  assign in_ready  = ((r_state == IDLE) || (r_state == FILL)) && (r_n < NW'(MAX_WORDS));
  assign w_accept  = in_valid && in_ready;
  assign w_nNext   = r_n + 1'b1;
  assign w_full    = (w_nNext == NW'(MAX_WORDS));
  assign w_sending = (r_state == HDR) || (r_state == DATA);

  // Lengths and header checksum derive from the word count; the checksum field itself counts as zero.
  assign w_payBytes = 11'({r_n, 2'b00});
  assign w_ipLenN   = 16'd28 + 16'(w_payBytes);
  assign w_udpLenN  = 16'd8 + 16'(w_payBytes);
  assign w_sum      = 20'h04500 + 20'(w_ipLenN) + 20'(r_ipId) + 20'({TTL, 8'h11})
                    + 20'(MY_IP[31:16]) + 20'(MY_IP[15:0])
                    + 20'(DST_IP[31:16]) + 20'(DST_IP[15:0]);
  assign w_fold1    = {1'b0, w_sum[15:0]} + 17'(w_sum[19:16]);
  assign w_fold2    = w_fold1[15:0] + 16'(w_fold1[16]);
  assign w_frameLen = 11'd42 + w_payBytes;
  assign w_txCountN = (w_frameLen < 11'd60) ? 11'd60 : w_frameLen;

  assign w_hdr = {DST_HWADDR, MY_HWADDR, 16'h0800, 16'h4500, r_ipLen, r_ipId, 16'h0000,
                  TTL, 8'h11, r_cksum, MY_IP, DST_IP, SRC_PORT, DST_PORT, r_udpLen, 16'h0000};
  assign w_hdrIdx = 6'd41 - tx_addr[5:0];
  assign w_off    = tx_addr - 11'd42;
  assign w_word   = r_buf[w_off[AW+1:2]];

  always_comb begin
    w_byte = 8'h00;
    if (tx_addr < 11'd42) begin
      w_byte = w_hdr[{w_hdrIdx, 3'b000} +: 8];
    end else if (w_off < w_payBytes) begin
      case (w_off[1:0])
        2'd0:    w_byte = w_word[31:24];
        2'd1:    w_byte = w_word[23:16];
        2'd2:    w_byte = w_word[15:8];
        default: w_byte = w_word[7:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_n[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_n       <= '0;
      r_ipId    <= '0;
      r_ipLen   <= '0;
      r_udpLen  <= '0;
      r_cksum   <= '0;
      r_txCount <= '0;
      r_txData  <= '0;
    end else begin
      if (w_accept) begin
        r_n <= w_nNext;
      end
      if (tx_adv && w_sending) begin
        r_txData <= w_byte;
      end
      case (r_state)
        IDLE, FILL: begin
          if (w_accept) begin
            r_state <= (in_last || w_full) ? CSUM : FILL;
          end
        end
        CSUM: begin
          r_ipLen   <= w_ipLenN;
          r_udpLen  <= w_udpLenN;
          r_cksum   <= ~w_fold2;
          r_txCount <= w_txCountN;
          r_state   <= ARB;
        end
        ARB: begin
          if (tx_grant) begin
            r_state <= HDR;
          end
        end
        HDR: begin
          if (tx_adv && (tx_addr == 11'd41)) begin
            r_state <= DATA;
          end
        end
        DATA: begin
          if (tx_last) begin
            r_state <= IDLE;
            r_n     <= '0;
            r_ipId  <= r_ipId + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_req   = (r_state == ARB);
  assign tx_count = (r_state == ARB) ? r_txCount : 11'd0;
  assign tx_data  = w_sending ? r_txData : 8'h00;

endmodule

// File: tb/tb_udp_tx_stream.sv
// Directed bench for udp_tx_stream: sends datagrams, plays the MAC/arbiter side and
// compares captured frame bytes against hand-computed tables.
module tb_udp_tx_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_req;
  logic [10:0] tx_count;
  logic        tx_grant;
  logic [10:0] tx_addr;
  logic        tx_adv;
  logic        tx_last;
  logic [7:0]  tx_data;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;

  udp_tx_stream dut (
    .clk      (clk),
    .reset    (reset),
    .tx_req   (tx_req),
    .tx_count (tx_count),
    .tx_grant (tx_grant),
    .tx_addr  (tx_addr),
    .tx_adv   (tx_adv),
    .tx_last  (tx_last),
    .tx_data  (tx_data),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         frame;
    int         addr;
    logic [7:0] exp;
  } vec_t;

  vec_t        vecs[$];
  int          total = 0;
  int          bad = 0;
  logic [7:0]  cap [5][300];
  logic [31:0] words [64];
  logic [479:0] f0Exp;

  function automatic void addVec(input string n, input int f, input int a, input logic [7:0] e);
    vec_t v;
    v.name  = n;
    v.frame = f;
    v.addr  = a;
    v.exp   = e;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    @(posedge clk);
    #1;
  endtask

  // gapAfter inserts an idle cycle carrying a stray in_last after that word index.
  task automatic sendFrame(input int n, input bit withLast, input int gapAfter);
    for (int i = 0; i < n; i++) begin
      checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
      applyStimulus(1'b1, words[i], withLast && (i == n - 1));
      if (i == gapAfter) begin
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("stray_last_no_launch", 32'(tx_req), 32'd0);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("in_ready_after_last", 32'(in_ready), 32'd0);
  endtask

  task automatic waitReq(input int expCount);
    int c;
    c = 0;
    checkOutput("tx_count_not_arb", 32'(tx_count), 32'd0);
    while (!tx_req && c < 20) begin
      @(posedge clk);
      #1;
      c++;
    end
    checkOutput("tx_req_wait", 32'(tx_req), 32'd1);
    checkOutput("tx_count", 32'(tx_count), 32'(expCount));
  endtask

  task automatic grantAndWalk(input int frame, input int count);
    tx_grant = 1'b1;
    @(posedge clk);
    #1;
    tx_grant = 1'b0;
    checkOutput("tx_req_after_grant", 32'(tx_req), 32'd0);
    for (int a = 0; a < count; a++) begin
      tx_addr = 11'(a);
      tx_adv  = 1'b1;
      @(posedge clk);
      #1;
      cap[frame][a] = tx_data;
    end
    tx_adv  = 1'b0;
    tx_last = 1'b1;
    @(posedge clk);
    #1;
    tx_last = 1'b0;
    checkOutput("idle_tx_data", 32'(tx_data), 32'd0);
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset    = 1'b1;
    tx_grant = 1'b0;
    tx_addr  = '0;
    tx_adv   = 1'b0;
    tx_last  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;

    f0Exp = {48'h985aebdd1c64, 48'h985aebdd1c65, 16'h0800, 16'h4500, 16'h0020, 16'h0000,
             16'h0000, 16'h4011, 16'hf575, 32'hc0a80205, 32'hc0a80202, 16'h4e50, 16'h4e50,
             16'h000c, 16'h0000, 32'h01020304, 112'h0};

    addVec("f1_id_hi", 1, 18, 8'h00);     addVec("f1_id_lo", 1, 19, 8'h01);
    addVec("f1_ck_hi", 1, 24, 8'hf5);     addVec("f1_ck_lo", 1, 25, 8'h74);
    addVec("f1_len_lo", 1, 17, 8'h20);
    addVec("f2_len_hi", 2, 16, 8'h00);    addVec("f2_len_lo", 2, 17, 8'h30);
    addVec("f2_udp_hi", 2, 38, 8'h00);    addVec("f2_udp_lo", 2, 39, 8'h1c);
    addVec("f2_ck_hi", 2, 24, 8'hf5);     addVec("f2_ck_lo", 2, 25, 8'h63);
    addVec("f2_id_lo", 2, 19, 8'h02);
    addVec("f2_pay42", 2, 42, 8'h11);     addVec("f2_pay45", 2, 45, 8'h44);
    addVec("f2_pay46", 2, 46, 8'h55);     addVec("f2_pay58", 2, 58, 8'ha5);
    addVec("f2_pay61", 2, 61, 8'h5a);
    addVec("f3_len_hi", 3, 16, 8'h01);    addVec("f3_len_lo", 3, 17, 8'h1c);
    addVec("f3_udp_hi", 3, 38, 8'h01);    addVec("f3_udp_lo", 3, 39, 8'h08);
    addVec("f3_ck_hi", 3, 24, 8'hf4);     addVec("f3_ck_lo", 3, 25, 8'h76);
    addVec("f3_id_lo", 3, 19, 8'h03);
    addVec("f3_pay42", 3, 42, 8'h00);     addVec("f3_pay169", 3, 169, 8'h7f);
    addVec("f3_pay297", 3, 297, 8'hff);
    addVec("f4_id_hi", 4, 18, 8'h00);     addVec("f4_id_lo", 4, 19, 8'h00);
    addVec("f4_ck_hi", 4, 24, 8'hf5);     addVec("f4_ck_lo", 4, 25, 8'h75);
    addVec("f4_pay42", 4, 42, 8'h01);     addVec("f4_pay45", 4, 45, 8'h04);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_tx_req", 32'(tx_req), 32'd0);
    checkOutput("reset_tx_count", 32'(tx_count), 32'd0);
    checkOutput("reset_tx_data", 32'(tx_data), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    // Frame 0 and its repeat: single word, padded to the 60-byte minimum.
    words[0] = 32'h01020304;
    sendFrame(1, 1'b1, -1);
    waitReq(60);
    grantAndWalk(0, 60);
    for (int a = 0; a < 60; a++) begin
      checkOutput($sformatf("f0_byte%0d", a), 32'(cap[0][a]), 32'(f0Exp[8*(59-a) +: 8]));
    end

    sendFrame(1, 1'b1, -1);
    waitReq(60);
    grantAndWalk(1, 60);

    // Five words with a stray in_last (no valid) after the second word.
    words[0] = 32'h11223344;
    words[1] = 32'h55667788;
    words[2] = 32'h99aabbcc;
    words[3] = 32'hddeeff00;
    words[4] = 32'ha5a55a5a;
    sendFrame(5, 1'b1, 1);
    waitReq(62);
    grantAndWalk(2, 62);

    // Full buffer with no in_last launches on its own; payload byte k equals k.
    for (int i = 0; i < 64; i++) begin
      words[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    end
    sendFrame(64, 1'b0, -1);
    waitReq(298);
    grantAndWalk(3, 298);

    // Reset while streaming payload at address 44.
    words[0] = 32'hcafebabe;
    sendFrame(1, 1'b1, -1);
    waitReq(60);
    tx_grant = 1'b1;
    @(posedge clk);
    #1;
    tx_grant = 1'b0;
    for (int a = 0; a < 44; a++) begin
      tx_addr = 11'(a);
      tx_adv  = 1'b1;
      @(posedge clk);
      #1;
    end
    checkOutput("f_rst_byte43", 32'(tx_data), 32'hfe);
    tx_addr = 11'd44;
    reset   = 1'b1;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    tx_adv = 1'b0;
    checkOutput("midreset_tx_data", 32'(tx_data), 32'd0);
    checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midreset_tx_req", 32'(tx_req), 32'd0);

    words[0] = 32'h01020304;
    sendFrame(1, 1'b1, -1);
    waitReq(60);
    grantAndWalk(4, 60);

    foreach (vecs[i]) begin
      checkOutput(vecs[i].name, 32'(cap[vecs[i].frame][vecs[i].addr]), 32'(vecs[i].exp));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/udp_tx_stream.md
UDP_TX_STREAM -- requirements
Module: udp_tx_stream

Interface
REQ-001 SHALL have parameter MY_HWADDR, default 48'h985aebdd1c65, Ethernet source MAC.
REQ-002 SHALL have parameter DST_HWADDR, default 48'h985aebdd1c64, Ethernet destination MAC.
REQ-003 SHALL have parameter MY_IP, default 32'hc0a80205, IPv4 source address.
REQ-004 SHALL have parameter DST_IP, default 32'hc0a80202, IPv4 destination address.
REQ-005 SHALL have parameter SRC_PORT, default 16'h4e50, UDP source port.
REQ-006 SHALL have parameter DST_PORT, default 16'h4e50, UDP destination port.
REQ-007 SHALL have parameter TTL, default 8'h40, IPv4 TTL.
REQ-008 SHALL have parameter MAX_WORDS, default 64, payload buffer depth in 32-bit words; legal range 1..368.
REQ-009 SHALL have port clk, input, 1, clock; all logic on posedge.
REQ-010 SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-011 SHALL have port tx_req, output, 1, arbiter request.
REQ-012 SHALL have port tx_count, output, 11, frame byte count for the arbiter.
REQ-013 SHALL have port tx_grant, input, 1, arbiter grant.
REQ-014 SHALL have ports tx_addr (input, 11, MAC byte index), tx_adv (input, 1, MAC byte advance) and tx_last (input, 1, MAC final byte).
REQ-015 SHALL have port tx_data, output, 8, frame byte to the MAC.
REQ-016 SHALL have ports in_valid (input, 1), in_data (input, 32, payload word) and in_last (input, 1, final word of datagram).
REQ-017 SHALL have port in_ready, output, 1, payload accept.

Function
REQ-018 SHALL use the one-hot states IDLE, FILL, CSUM, ARB, HDR and DATA.
REQ-019 SHALL accept a word when in_valid & in_ready, storing it at buffer index N and incrementing word count N.
REQ-020 SHALL drive in_ready = (IDLE|FILL) & (N < MAX_WORDS).
- IDLE->FILL on an accept without launch.
- IDLE|FILL->CSUM on an accept with in_last, or on the accept that makes N == MAX_WORDS.
REQ-021 SHALL compute, in CSUM (1 cycle), the payload bytes P = 4N, IP total length 28+P, UDP length 8+P and the IPv4 header checksum, then go to ARB.
- Checksum is the 16-bit ones-complement sum of the header words (checksum field = 0), end-around carry folded, then inverted.
REQ-022 SHALL drive tx_req = ARB and tx_count = ARB ? max(60, 42+P) : 0.
- ARB->HDR on tx_grant.
- HDR->DATA on tx_adv & tx_addr == 41.
- DATA->IDLE on tx_last, clearing N.
REQ-023 SHALL, on tx_adv while in HDR|DATA, load tx_data_q with the byte for tx_addr; tx_data = (HDR|DATA) ? tx_data_q : 0, so latency is 1 cycle after tx_adv.
REQ-024 SHALL map frame bytes as follows, all multi-byte fields MSB first.
- 0-5 DST_HWADDR; 6-11 MY_HWADDR; 12-13 08 00; 14-15 45 00.
- 16-17 IP total length; 18-19 IP ID; 20-21 00 00; 22 TTL; 23 11; 24-25 checksum.
- 26-29 MY_IP; 30-33 DST_IP; 34-35 SRC_PORT; 36-37 DST_PORT; 38-39 UDP length; 40-41 00 00.
- 42..41+P payload: word (a-42)>>2, byte (a-42)&3, byte 0 = bits 31:24.
- All other addresses 00 (pad).
REQ-025 SHALL hold a 16-bit IP ID, 0 after reset, incremented (mod 2^16) on each DATA->IDLE transition.
REQ-026 SHALL ignore in_valid while in_ready is low; in_last with in_valid low has no effect.
REQ-027 SHALL hold tx_data_q when tx_adv is seen outside HDR|DATA.

Reset
REQ-028 SHALL on reset, including mid-frame, enter IDLE and clear N, IP ID and tx_data_q.
- Resulting outputs: tx_req=0, tx_count=0, tx_data=0, in_ready=1.
- The buffer contents need not be cleared.

Verification
REQ-029 SHALL cover the reset case: reset held 2 cycles -> tx_req=0, tx_count=0, tx_data=0, in_ready=1.
REQ-030 SHALL cover a one-word frame: word 32'h01020304 with in_last, grant, MAC walks addresses 0..59.
- tx_req with tx_count=60.
- Bytes 16-17 = 00 20, 18-19 = 00 00, 24-25 = F5 75, 38-39 = 00 0C, 42-45 = 01 02 03 04, 46-59 = 00.
- Returns to IDLE on tx_last.
REQ-031 SHALL cover a repeat of the one-word frame -> ID = 00 01, checksum = F5 74.
REQ-032 SHALL cover a 5-word frame with in_last on the 5th word -> tx_count=62, IP length 00 30, UDP length 00 1C, no pad bytes.
REQ-033 SHALL cover MAX_WORDS=64 words with no in_last.
- in_ready low from the cycle after the 64th accept; auto launch.
- tx_count=298, IP length 01 1C, UDP length 01 08.
REQ-034 SHALL cover reset asserted in DATA at address 44 -> next cycle IDLE, tx_data=0; the following frame carries ID 00 00.
